// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: picks one ready warp per cycle in round-robin order,
// blocks warps with an unresolved branch, and counts issued instructions.
module warp_issue_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  IB_Ready_Issue_IU,
  input  logic        OC_Avail,
  input  logic        BEQ_Out,
  input  logic        BLT_Out,
  input  logic        Branch_Resolve_EX,
  input  logic [2:0]  Branch_WarpID_EX,
  output logic [7:0]  IU_Grant,
  output logic [2:0]  Issue_WarpID_OC,
  output logic [7:0]  Branch_Pending,
  output logic [15:0] Issue_Cnt
);

  logic [2:0]  rr_ptr_reg;
  logic [2:0]  rr_ptr_next;
  logic [7:0]  branch_pending_reg;
  logic [7:0]  branch_pending_next;
  logic [15:0] issue_cnt_reg;
  logic [15:0] issue_cnt_next;

  logic [7:0]  eligible;
  logic [7:0]  eligible_rot;
  logic        grant_valid;
  logic [2:0]  grant_off;
  logic [2:0]  grant_idx;
  logic [7:0]  set_mask;
  logic [7:0]  clr_mask;

  // Pending-branch warps are never eligible; no issue without a collector slot or in reset.
  assign eligible = (rst || !OC_Avail) ? 8'h00 : (IB_Ready_Issue_IU & ~branch_pending_reg);

  // Rotate so that bit 0 of eligible_rot is the warp at the round-robin pointer.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign eligible_rot[gi] = eligible[rr_ptr_reg + 3'(gi)];
  end

  // Lowest set bit of the rotated vector is the first eligible warp upward from the pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_off   = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (eligible_rot[j]) begin
        grant_valid = 1'b1;
        grant_off   = 3'(j);
      end
    end
  end

  // Modulo-8 add brings the offset back into absolute warp numbering.
  assign grant_idx = rr_ptr_reg + grant_off;

  // One-hot grant; the branch flags never feed this path, so no loop through the IB mux.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grant
    assign IU_Grant[gi] = grant_valid && (grant_idx == 3'(gi));
  end

  assign Issue_WarpID_OC = grant_valid ? grant_idx : 3'd0;

  // Next-state for pointer, branch mask and counter; a set beats a clear on the same warp.
  always_comb begin
    set_mask            = 8'h00;
    clr_mask            = 8'h00;
    rr_ptr_next         = rr_ptr_reg;
    issue_cnt_next      = issue_cnt_reg;
    if (grant_valid) begin
      rr_ptr_next = grant_idx + 3'd1;
      if (issue_cnt_reg != 16'hFFFF) begin
        issue_cnt_next = issue_cnt_reg + 16'd1;
      end
      if (BEQ_Out || BLT_Out) begin
        set_mask = 8'h01 << grant_idx;
      end
    end
    if (Branch_Resolve_EX) begin
      clr_mask = 8'h01 << Branch_WarpID_EX;
    end
    branch_pending_next = (branch_pending_reg & ~clr_mask) | set_mask;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg         <= 3'd0;
      branch_pending_reg <= 8'h00;
      issue_cnt_reg      <= 16'd0;
    end else begin
      rr_ptr_reg         <= rr_ptr_next;
      branch_pending_reg <= branch_pending_next;
      issue_cnt_reg      <= issue_cnt_next;
    end
  end

  assign Branch_Pending = branch_pending_reg;
  assign Issue_Cnt      = issue_cnt_reg;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler with hand-computed expectations.
module tb_warp_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ib_ready;
  logic        oc_avail;
  logic        beq;
  logic        blt;
  logic        res;
  logic [2:0]  res_id;
  logic [7:0]  grant;
  logic [2:0]  warp_id;
  logic [7:0]  pending;
  logic [15:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  warp_issue_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .IB_Ready_Issue_IU (ib_ready),
    .OC_Avail          (oc_avail),
    .BEQ_Out           (beq),
    .BLT_Out           (blt),
    .Branch_Resolve_EX (res),
    .Branch_WarpID_EX  (res_id),
    .IU_Grant          (grant),
    .Issue_WarpID_OC   (warp_id),
    .Branch_Pending    (pending),
    .Issue_Cnt         (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, check the combinational grant, then clock it in.
  task automatic issue(input string tag, input logic [7:0] ib, input logic oc,
                       input logic b_eq, input logic b_lt, input logic r, input logic [2:0] rid,
                       input logic [7:0] exp_grant, input logic [2:0] exp_id);
    ib_ready = ib; oc_avail = oc; beq = b_eq; blt = b_lt; res = r; res_id = rid;
    #1;
    check({tag, "_grant"}, {8'h00, grant}, {8'h00, exp_grant});
    check({tag, "_id"}, {13'h0, warp_id}, {13'h0, exp_id});
    tick();
    beq = 1'b0; blt = 1'b0; res = 1'b0;
  endtask

  logic [7:0] exp_g;

  initial begin
    rst = 1'b1; ib_ready = 8'hFF; oc_avail = 1'b1; beq = 1'b0; blt = 1'b0; res = 1'b0; res_id = 3'd0;
    #1;
    check("rst_grant", {8'h00, grant}, 16'h0000);
    check("rst_id", {13'h0, warp_id}, 16'h0000);
    tick();
    check("rst_pending", {8'h00, pending}, 16'h0000);
    check("rst_cnt", cnt, 16'h0000);
    rst = 1'b0;

    // Round robin over all warps, wrapping back to warp 0.
    for (int i = 0; i < 9; i++) begin
      exp_g = 8'h01 << (i % 8);
      issue("rr", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, exp_g, 3'(i % 8));
    end
    check("rr_cnt", cnt, 16'd9);

    // OC stall: pointer is 1; no grant while OC busy, then warp 2, then warp 5.
    for (int i = 0; i < 3; i++) issue("stall", 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    issue("stall_rel", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 3'd2);
    issue("stall_next", 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5);
    check("stall_cnt", cnt, 16'd11);

    // Branch block on warp 3.
    issue("br_set", 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 3'd3);
    check("br_pending", {8'h00, pending}, 16'h0008);
    issue("br_blk0", 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    issue("br_blk1", 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 3'd0);
    check("br_clear", {8'h00, pending}, 16'h0000);
    issue("br_free", 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 3'd3);
    check("br_cnt", cnt, 16'd13);

    // Same-warp set and resolve: set wins. Pointer is 4.
    issue("sc_same", 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 3'd5);
    check("sc_same_pend", {8'h00, pending}, 16'h0020);
    issue("sc_w2", 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h04, 3'd2);
    check("sc_w2_pend", {8'h00, pending}, 16'h0024);
    // Set warp 1 while resolving warp 2 (pointer 3, search wraps to 1).
    issue("sc_diff", 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'h02, 3'd1);
    check("sc_diff_pend", {8'h00, pending}, 16'h0022);
    // Resolve to a non-pending warp is ignored; pending warp 5 stays blocked.
    issue("sc_ignore", 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 3'd0);
    check("sc_ignore_pend", {8'h00, pending}, 16'h0022);
    // Pointer 2: warps 1 and 5 pending, so warp 2 wins.
    issue("sc_mask", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h04, 3'd2);
    issue("sc_clr1", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 3'd0);
    check("sc_all_clear", {8'h00, pending}, 16'h0000);
    check("sc_cnt", cnt, 16'd17);

    // Wrap: pointer 3 -> grant warp 6 moves it to 7; then 80, then 01.
    issue("wrap_w6", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h40, 3'd6);
    issue("wrap_w7", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h80, 3'd7);
    issue("wrap_w0", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0);
    check("wrap_cnt", cnt, 16'd20);

    // Saturation: 65540 more grants push well past the maximum.
    ib_ready = 8'hFF; oc_avail = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("sat_cnt", cnt, 16'hFFFF);
    issue("sat_more", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0);
    check("sat_hold", cnt, 16'hFFFF);

    // Reset mid-operation: build pending=12 and count=40 from a clean start.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 38; i++) tick();
    issue("mid_w1", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 3'd1);
    issue("mid_w4", 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10, 3'd4);
    check("mid_pend", {8'h00, pending}, 16'h0012);
    check("mid_cnt", cnt, 16'd40);
    rst = 1'b1;
    issue("mid_rst", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0);
    rst = 1'b0;
    check("mid_rst_pend", {8'h00, pending}, 16'h0000);
    check("mid_rst_cnt", cnt, 16'h0000);
    issue("mid_after", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 3'd0);
    check("mid_after_cnt", cnt, 16'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port IB_Ready_Issue_IU, input, 8 bits: bit i set means warp i's instruction buffer head is valid and scoreboard-clear.
REQ-004 SHALL have port OC_Avail, input, 1 bit: the operand collector can accept one instruction this cycle.
REQ-005 SHALL have ports BEQ_Out and BLT_Out, inputs, 1 bit each: branch flags of the instruction selected by IU_Grant (same cycle).
REQ-006 SHALL have ports Branch_Resolve_EX, input, 1 bit, and Branch_WarpID_EX, input, 3 bits: a branch for warp Branch_WarpID_EX has resolved.
REQ-007 SHALL have port IU_Grant, output, 8 bits: one-hot issue grant, combinational, or all-zero.
REQ-008 SHALL have port Issue_WarpID_OC, output, 3 bits: encoded index of the granted warp, combinational; 0 when no grant.
REQ-009 SHALL have port Branch_Pending, output, 8 bits: registered per-warp branch-in-flight mask.
REQ-010 SHALL have port Issue_Cnt, output, 16 bits: registered count of issued instructions.

Function
REQ-011 SHALL compute Eligible = IB_Ready_Issue_IU & ~Branch_Pending, gated to all-zero when OC_Avail=0 or rst=1.
REQ-012 SHALL hold a 3-bit round-robin pointer RR_Ptr.
REQ-013 SHALL grant the first eligible warp found by searching circularly upward from RR_Ptr (RR_Ptr, RR_Ptr+1, ..., wrapping 7->0).
REQ-014 SHALL assert at most one IU_Grant bit per cycle; IU_Grant is zero when Eligible is zero.
REQ-015 SHALL make IU_Grant independent of BEQ_Out and BLT_Out, so that no combinational loop forms through the instruction-buffer output mux.
REQ-016 SHALL, on a grant to warp k, load RR_Ptr <= (k+1) mod 8 at the next edge.
REQ-017 SHALL leave RR_Ptr unchanged in any cycle with no grant.
REQ-018 SHALL, on a grant to warp k with BEQ_Out|BLT_Out = 1, set Branch_Pending[k] at the next edge.
REQ-019 SHALL, when Branch_Resolve_EX=1, clear Branch_Pending[Branch_WarpID_EX] at the next edge.
REQ-020 SHALL ignore a resolve that targets a non-pending warp.
REQ-021 SHALL let set win when set and clear target the same warp in the same cycle.
REQ-022 SHALL apply set and clear independently when they target different warps in the same cycle.
REQ-023 SHALL never grant a warp whose Branch_Pending bit is set, even if its IB_Ready_Issue_IU bit is high.
REQ-024 SHALL increment Issue_Cnt by 1 on each grant.
REQ-025 SHALL saturate Issue_Cnt at 16'hFFFF; no wrap.
REQ-026 SHALL produce a grant with zero latency: a request and OC_Avail in cycle N yield IU_Grant in cycle N.
REQ-027 SHALL make a warp freed by resolve in cycle N eligible from cycle N+1.

Reset
REQ-028 SHALL, while rst=1, force IU_Grant=0 and Issue_WarpID_OC=0.
REQ-029 SHALL, at a rising edge with rst=1, set RR_Ptr=0, Branch_Pending=8'h00 and Issue_Cnt=0.
REQ-030 SHALL let reset asserted mid-operation discard all pending branches, with no grant issued in the reset cycle.
REQ-031 SHALL make warp 0 top priority in the first cycle after reset release.

Verification
REQ-032 SHALL cover round robin: IB_Ready=8'hFF, OC_Avail=1 for 9 cycles -> grants 01,02,04,...,80,01; Issue_Cnt=9.
REQ-033 SHALL cover the OC stall: IB_Ready=8'h24, OC_Avail=0 for 3 cycles, then 1 -> no grant for 3 cycles, then grant 8'h04; RR_Ptr then 3; next grant 8'h20.
REQ-034 SHALL cover branch block: grant warp 3 with BEQ_Out=1 -> Branch_Pending=8'h08; IB_Ready=8'h08 gives no grant until Branch_Resolve_EX=1 with ID 3; grant 8'h08 the cycle after resolve.
REQ-035 SHALL cover same-cycle set and clear: grant warp 5 with BLT_Out=1 while resolve targets warp 5 -> Branch_Pending[5]=1. In the same cycle as another warp's set, resolve of pending warp 2 -> bit 2 cleared, other bit set.
REQ-036 SHALL cover wrap and saturation: RR_Ptr=7, IB_Ready=8'h81 -> grant 8'h80, then 8'h01. Issue_Cnt preloaded near max by 65540 grants -> holds 16'hFFFF.
REQ-037 SHALL cover reset mid-operation: Branch_Pending=8'h12, Issue_Cnt=40, rst=1 one cycle -> IU_Grant=0 that cycle; afterwards all state zero; IB_Ready=8'hFF grants 8'h01.
